iomem_byte_master: RTL and testbench
====================================

Name: iomem_byte_master

Overview:
Byte-stream-to-iomem bus initiator, acting as the other end of the iomem bus from the GPIO/peripheral responders. A host link (e.g. a UART receiver/transmitter pair) feeds command bytes in. The block decodes them, issues single 32-bit read/write transactions on an iomem-style port, and streams response bytes back. Used as a debug/bring-up master for peripherals at 0x03xx_xxxx.

Parameters:
TIMEOUT, 1023, max cycles iomem_valid is held without iomem_ready before the transfer is aborted
TO_W, 10, width of timeout counter (must hold TIMEOUT)

Ports:
clk  input  1  system clock
resetn  input  1  reset, synchronous, active-low
rx_data  input  8  command byte in
rx_valid  input  1  rx_data valid
rx_ready  output  1  block accepts rx_data this cycle (transfer when rx_valid & rx_ready)
tx_data  output  8  response byte out
tx_valid  output  1  tx_data valid
tx_ready  input  1  sink accepts tx_data (transfer when tx_valid & tx_ready)
iomem_valid  output  1  bus request
iomem_ready  input  1  responder completion pulse
iomem_wstrb  output  4  byte strobes; 4'hF for write, 4'h0 for read
iomem_addr  output  32  bus address
iomem_wdata  output  32  write data
iomem_rdata  input  32  read data, valid when iomem_ready=1
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: clk and resetn as decided; reset is synchronous, active-low. On reset: state=IDLE; rx_ready=0 during reset, 1 the first cycle after; tx_valid=0, tx_data=0; iomem_valid=0, iomem_wstrb=0, iomem_addr=0, iomem_wdata=0; busy=0; counters cleared. Reset mid-transaction aborts immediately; no response byte is emitted.
- Framing, all multi-byte fields MSB first:
  - Write: 0x57, A3..A0, D3..D0 -> response 0x4B.
  - Read: 0x52, A3..A0 -> response R3..R0.
  - Any other first byte -> response 0x45; the byte is consumed.
  - Timeout -> response 0x54 only, for both reads and writes.
- States: IDLE, ADDR, DATA, BUS, RESP.
  - IDLE: rx_ready=1. On accept: 0x57/0x52 -> ADDR with byte count=0 and the cmd latched. Otherwise load 0x45 -> RESP.
  - ADDR: rx_ready=1. Shift each accepted byte into addr. After the 4th byte: write -> DATA, read -> BUS.
  - DATA: rx_ready=1. Shift 4 bytes into wdata, then -> BUS.
  - BUS: rx_ready=0.
    - iomem_valid rises the cycle after entry. addr, wdata and wstrb are stable for as long as valid=1.
    - On iomem_ready=1: latch rdata (read) and drop iomem_valid on the next edge. Load the response: 1 byte (0x4B) or 4 bytes (rdata[31:24] first). Go to RESP.
    - Timeout counter increments each cycle valid=1. If it reaches TIMEOUT with ready=0: drop valid, load 0x54, go to RESP.
    - ready and timeout in the same cycle: ready wins.
    - iomem_ready while valid=0 is ignored.
  - RESP: rx_ready=0. tx_valid=1 with tx_data stable until tx_ready. On each handshake, advance to the next byte. The last byte's handshake clears tx_valid on that edge and returns to IDLE.
- No pipelining: exactly one bus transaction in flight.
- Back-to-back latency: a new command byte is accepted the cycle after the final response handshake.
- The DATA phase accepts stalls (rx_valid gaps) indefinitely; there is no inter-byte timeout.
- Minimum write latency: last data byte accepted at cycle N, iomem_valid=1 at N+1. With a 1-cycle responder, ready at N+2 and tx_valid=1 at N+3.

Test Plan:
- Write 57 03 00 00 00 DE AD BE EF; responder ready 1 cycle after valid -> one transaction addr=0x03000000, wdata=0xDEADBEEF, wstrb=F; valid drops the cycle after ready; tx emits 0x4B.
- Read 52 03 00 00 00; responder returns 0x000000A5 -> wstrb=0, tx bytes 00 00 00 A5 in order, tx_ready toggled 50% randomly, tx_data stable while stalled.
- Responder never asserts ready -> iomem_valid high for exactly TIMEOUT=1023 cycles then low; tx emits 0x54 only; next command is accepted normally.
- Bad command 0x99 -> tx 0x45, state returns to IDLE, no iomem_valid pulse. A following valid read completes correctly.
- resetn low for 1 cycle during the DATA phase (after 2 data bytes) -> all outputs zero; a subsequent full write completes with the new data only.
- Ready arriving on the same cycle the timeout count hits TIMEOUT (TIMEOUT=4 override) -> treated as success: 0x4B, or read data for a read.

Source files
------------

// File: rtl/iomem_byte_master.sv
// iomem_byte_master: byte-stream command decoder driving single 32-bit iomem transactions.
//
// Ports:
//   clk, resetn        clock and synchronous active-low reset
//   rx_data/valid/ready  command byte stream in (transfer on valid & ready)
//   tx_data/valid/ready  response byte stream out (transfer on valid & ready)
//   iomem_valid/ready    bus request / responder completion pulse
//   iomem_wstrb          4'hF on writes, 4'h0 on reads
//   iomem_addr/wdata     bus address and write data, stable while iomem_valid
//   iomem_rdata          read data, sampled when iomem_ready
//   busy                 high whenever a command is in progress
//
// Frames (MSB first): 57 A3..A0 D3..D0 -> 4B; 52 A3..A0 -> R3..R0;
// unknown first byte -> 45; bus timeout -> 54.
module iomem_byte_master #(
    parameter int TIMEOUT = 1023,
    parameter int TO_W    = 10
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        iomem_valid,
    input  logic        iomem_ready,
    output logic [3:0]  iomem_wstrb,
    output logic [31:0] iomem_addr,
    output logic [31:0] iomem_wdata,
    input  logic [31:0] iomem_rdata,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

    state_t      state, state_next;
    logic        is_wr;
    logic [1:0]  byte_cnt;
    logic [1:0]  resp_left;
    logic [31:0] resp;
    logic [TO_W-1:0] to_cnt;
    logic        rx_fire, tx_fire, bus_done, bus_to;

    assign rx_ready = resetn && (state == IDLE || state == ADDR || state == DATA);
    assign tx_valid = state == RESP;
    assign tx_data  = resp[31:24];
    assign busy     = state != IDLE;
    assign rx_fire  = rx_valid && rx_ready;
    assign tx_fire  = tx_valid && tx_ready;
    assign bus_done = iomem_valid && iomem_ready;
    // The last permitted valid cycle is the one where to_cnt == TIMEOUT-1;
    // a ready in that same cycle still counts as success.
    assign bus_to   = iomem_valid && !iomem_ready && to_cnt == TO_W'(TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (rx_fire) state_next = (rx_data == 8'h57 || rx_data == 8'h52) ? ADDR : RESP;
            ADDR: if (rx_fire && byte_cnt == 2'd3) state_next = is_wr ? DATA : BUS;
            DATA: if (rx_fire && byte_cnt == 2'd3) state_next = BUS;
            BUS:  if (bus_done || bus_to) state_next = RESP;
            RESP: if (tx_fire && resp_left == 2'd0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            is_wr       <= 1'b0;
            byte_cnt    <= 2'd0;
            resp_left   <= 2'd0;
            resp        <= 32'h0;
            to_cnt      <= '0;
            iomem_valid <= 1'b0;
            iomem_wstrb <= 4'h0;
            iomem_addr  <= 32'h0;
            iomem_wdata <= 32'h0;
        end else begin
            // The error byte is preloaded on every command byte; a valid
            // command overwrites it once the bus transfer finishes.
            if (rx_fire && state == IDLE) begin
                is_wr     <= rx_data == 8'h57;
                resp      <= {8'h45, 24'h0};
                resp_left <= 2'd0;
            end
            if (rx_fire)
                byte_cnt <= state == IDLE ? 2'd0 : byte_cnt + 2'd1;
            if (rx_fire && state == ADDR)
                iomem_addr <= {iomem_addr[23:0], rx_data};
            if (rx_fire && state == DATA)
                iomem_wdata <= {iomem_wdata[23:0], rx_data};
            if (state != BUS && state_next == BUS) begin
                iomem_valid <= 1'b1;
                iomem_wstrb <= is_wr ? 4'hF : 4'h0;
                to_cnt      <= '0;
            end
            if (bus_done || bus_to) begin
                iomem_valid <= 1'b0;
                iomem_wstrb <= 4'h0;
                resp        <= bus_done ? (is_wr ? {8'h4B, 24'h0} : iomem_rdata) : {8'h54, 24'h0};
                resp_left   <= (bus_done && !is_wr) ? 2'd3 : 2'd0;
            end else if (iomem_valid) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            if (tx_fire) begin
                resp      <= {resp[23:0], 8'h0};
                resp_left <= resp_left - 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_iomem_byte_master.sv
// tb_iomem_byte_master: directed self-checking bench with a frame-level reference model.
module tb_iomem_byte_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn = 1'b0;
    logic        sel = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_valid = 1'b0;
    logic        tx_ready = 1'b0;
    logic        m_ready = 1'b0;
    logic [31:0] rd_val = 32'h0;
    logic        junk = 1'b0;
    int          resp_lat = -1;
    bit          rand_tx = 1'b0;
    logic [31:0] m_rdata;
    assign m_rdata = m_ready ? rd_val : 32'h5A5A1234;

    logic rr0, tv0, iv0, bz0, rr4, tv4, iv4, bz4;
    logic [7:0]  td0, td4;
    logic [3:0]  ws0, ws4;
    logic [31:0] ia0, ia4, iw0, iw4;

    iomem_byte_master dut (
        .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid && !sel), .rx_ready(rr0),
        .tx_data(td0), .tx_valid(tv0), .tx_ready(tx_ready && !sel), .iomem_valid(iv0),
        .iomem_ready(m_ready && !sel), .iomem_wstrb(ws0), .iomem_addr(ia0), .iomem_wdata(iw0),
        .iomem_rdata(m_rdata), .busy(bz0)
    );

    iomem_byte_master #(.TIMEOUT(4), .TO_W(3)) dut4 (
        .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid && sel), .rx_ready(rr4),
        .tx_data(td4), .tx_valid(tv4), .tx_ready(tx_ready && sel), .iomem_valid(iv4),
        .iomem_ready(m_ready && sel), .iomem_wstrb(ws4), .iomem_addr(ia4), .iomem_wdata(iw4),
        .iomem_rdata(m_rdata), .busy(bz4)
    );

    logic        rx_ready, tx_valid, iomem_valid, busy;
    logic [7:0]  tx_data;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr, iomem_wdata;
    logic        iomem_ready;
    assign rx_ready    = sel ? rr4 : rr0;
    assign tx_valid    = sel ? tv4 : tv0;
    assign tx_data     = sel ? td4 : td0;
    assign iomem_valid = sel ? iv4 : iv0;
    assign busy        = sel ? bz4 : bz0;
    assign iomem_wstrb = sel ? ws4 : ws0;
    assign iomem_addr  = sel ? ia4 : ia0;
    assign iomem_wdata = sel ? iw4 : iw0;
    assign iomem_ready = m_ready;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, required 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    // Responder: raises ready in the (resp_lat+1)-th cycle of a valid pulse;
    // junk drives ready while no request is pending.
    int vcnt = 0;
    always @(posedge clk) begin
        #1;
        if (iomem_valid) begin
            vcnt++;
            m_ready = resp_lat >= 0 && vcnt == resp_lat + 1;
        end else begin
            vcnt = 0;
            m_ready = junk;
        end
        tx_ready = rand_tx ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Frame-level model state, filled by the stimulus for each command.
    logic [7:0]  exp_q[$];
    logic [7:0]  got[$];
    bit          exp_bus = 1'b0, exp_wr = 1'b0, final_byte = 1'b0;
    logic [31:0] exp_addr = 32'h0, exp_wdata = 32'h0;
    int          exp_vlen = 0, vlen = 0, last_vlen = 0;
    bit          prev_valid, chk_vnext, prev_done, prev_stall, prev_last;
    logic [7:0]  prev_data, e;

    always @(negedge clk) begin
        if (!resetn) begin
            vlen = 0; prev_valid = 0; chk_vnext = 0; prev_done = 0; prev_stall = 0; prev_last = 0;
        end else begin
            if (!exp_bus) chk("no_bus", 32'(iomem_valid), 32'd0);
            if (iomem_valid && exp_bus) begin
                chk("addr", iomem_addr, exp_addr);
                chk("wstrb", 32'(iomem_wstrb), exp_wr ? 32'hF : 32'h0);
                if (exp_wr) chk("wdata", iomem_wdata, exp_wdata);
            end
            if (iomem_valid) vlen++;
            else if (prev_valid) begin
                chk("valid_len", 32'(vlen), 32'(exp_vlen));
                last_vlen = vlen;
                vlen = 0;
            end
            if (chk_vnext) chk("valid_latency", 32'(iomem_valid), 32'd1);
            if (prev_done) chk("resp_latency", 32'({iomem_valid, tx_valid}), 32'd1);
            if (iomem_valid || tx_valid) chk("rx_blocked", 32'({rx_ready, busy}), 32'd1);
            if (prev_last) chk("b2b_ready", 32'({rx_ready, busy}), 32'd2);
            if (prev_stall) chk("tx_stable", 32'({tx_valid, tx_data}), 32'({1'b1, prev_data}));
            chk_vnext  = rx_valid && rx_ready && final_byte;
            prev_done  = iomem_valid && iomem_ready;
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            prev_last  = 0;
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL tx_extra: got byte 0x%h, required none at %0t", tx_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_byte", 32'(tx_data), 32'(e));
                    got.push_back(tx_data);
                    prev_last = exp_q.size() == 0;
                end
            end
            prev_valid = iomem_valid;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit ok = 0;
        rx_data = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            ok = rx_ready;
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL rx_accept: got no rx_ready, required accept of 0x%h", b);
        end
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic do_cmd(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] r, input int lat, input int gap);
        logic [7:0] q[$];
        int  t = sel ? 4 : 1023;
        bit  is_bus = c == 8'h57 || c == 8'h52;
        bit  wr = c == 8'h57;
        bit  to = !(lat >= 0 && lat + 1 <= t);
        bit  done = 0;
        exp_addr = a; exp_wdata = d; exp_wr = wr; exp_bus = is_bus;
        exp_vlen = to ? t : lat + 1;
        resp_lat = lat; rd_val = r;
        if (!is_bus) exp_q.push_back(8'h45);
        else if (to) exp_q.push_back(8'h54);
        else if (wr) exp_q.push_back(8'h4B);
        else for (int i = 3; i >= 0; i--) exp_q.push_back(r[i*8 +: 8]);
        got.delete();
        q.push_back(c);
        if (is_bus) for (int i = 3; i >= 0; i--) q.push_back(a[i*8 +: 8]);
        if (wr) for (int i = 3; i >= 0; i--) q.push_back(d[i*8 +: 8]);
        foreach (q[i]) begin
            if (wr && i > 5) repeat (gap) begin @(posedge clk); #1; end
            final_byte = is_bus && i == q.size() - 1;
            send_byte(q[i]);
            final_byte = 0;
        end
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            done = exp_q.size() == 0 && !busy;
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL cmd_done: got %0d bytes pending, required 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1 exp_bus = 0;
    endtask

    function automatic logic [31:0] packed_got();
        logic [31:0] w = 32'h0;
        foreach (got[i]) w = {w[23:0], got[i]};
        return w;
    endfunction

    task automatic chk_zero(input string name);
        chk({name, "_ctl"}, 32'({rx_ready, tx_valid, iomem_valid, busy, iomem_wstrb}), 32'h80);
        chk({name, "_txd"}, 32'(tx_data), 32'h0);
        chk({name, "_addr"}, iomem_addr, 32'h0);
        chk({name, "_wdata"}, iomem_wdata, 32'h0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rx_ready", 32'(rx_ready), 32'd0);
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1;

        do_cmd(8'h57, 32'h03000000, 32'hDEADBEEF, 32'h0, 1, 0);
        chk("lit_write_n", 32'(got.size()), 32'd1);
        chk("lit_write_ack", packed_got(), 32'h4B);

        rand_tx = 1;
        do_cmd(8'h52, 32'h03000000, 32'h0, 32'h000000A5, 1, 0);
        rand_tx = 0;
        chk("lit_read_n", 32'(got.size()), 32'd4);
        chk("lit_read_bytes", packed_got(), 32'h000000A5);

        do_cmd(8'h57, 32'h03000004, 32'h01020304, 32'h0, -1, 0);
        chk("lit_timeout_len", 32'(last_vlen), 32'd1023);
        chk("lit_timeout_resp", packed_got(), 32'h54);

        do_cmd(8'h52, 32'h03000008, 32'h0, 32'h89ABCDEF, 0, 0);
        chk("lit_read2", packed_got(), 32'h89ABCDEF);

        junk = 1;
        do_cmd(8'h99, 32'h0, 32'h0, 32'h0, -1, 0);
        junk = 0;
        chk("lit_bad_resp", packed_got(), 32'h45);
        do_cmd(8'h52, 32'h0300000C, 32'h0, 32'h13572468, 2, 0);

        rand_tx = 1;
        do_cmd(8'h57, 32'h03000014, 32'hCAFEBABE, 32'h0, 3, 3);
        rand_tx = 0;

        send_byte(8'h57);
        send_byte(8'h03); send_byte(8'h00); send_byte(8'h00); send_byte(8'h18);
        send_byte(8'hAA); send_byte(8'hBB);
        resetn = 1'b0;
        @(negedge clk);
        chk("midreset_rx_ready", 32'(rx_ready), 32'd0);
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk_zero("midreset");
        @(posedge clk);
        #1;
        do_cmd(8'h57, 32'h03000010, 32'h11223344, 32'h0, 1, 0);
        chk("lit_after_reset", packed_got(), 32'h4B);

        sel = 1;
        do_cmd(8'h57, 32'h03000020, 32'hA5A5A5A5, 32'h0, 3, 0);
        chk("lit_edge_wr_len", 32'(last_vlen), 32'd4);
        chk("lit_edge_wr_resp", packed_got(), 32'h4B);
        do_cmd(8'h52, 32'h03000024, 32'h0, 32'hCAFEF00D, 3, 0);
        chk("lit_edge_rd", packed_got(), 32'hCAFEF00D);
        do_cmd(8'h57, 32'h03000028, 32'h55667788, 32'h0, 4, 0);
        chk("lit_to4_resp", packed_got(), 32'h54);
        do_cmd(8'h52, 32'h0300002C, 32'h0, 32'h0BADF00D, -1, 0);
        chk("lit_to4_len", 32'(last_vlen), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, required summary before %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
